// File: rtl/axi_burst_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : axi_burst_pkg
// Purpose  : Shared burst encodings, FSM state type and small helper functions
//            for the AXI burst address generator.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package axi_burst_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Bytes transferred per beat for an AxSIZE encoding.
  function automatic int unsigned size_bytes(input logic [2:0] size);
    return 32'd1 << size;
  endfunction

  // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
  function automatic logic wrap_legal(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_beat_step.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : axi_beat_step
// Purpose  : Combinational next-beat address for FIXED / INCR / WRAP bursts.
//            Any burst code other than FIXED or WRAP steps as INCR.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module axi_beat_step
  import axi_burst_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic [AW-1:0] addr_i,
  input  logic [2:0]    size_i,
  input  logic [1:0]    burst_i,
  input  logic [AW-1:0] wrap_lo_i,
  input  logic [AW-1:0] wrap_mask_i,
  output logic [AW-1:0] next_addr_o
);

  logic [AW-1:0] w_sb;

  assign w_sb = AW'(size_bytes(size_i));

  // Select the address step rule for the active burst type.
  always_comb begin
    next_addr_o = addr_i;
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_WRAP:  next_addr_o = wrap_lo_i | ((addr_i + w_sb) & wrap_mask_i);
      // INCR realigns first, so only the opening beat can be unaligned.
      default:     next_addr_o = (addr_i & ~(w_sb - AW'(1))) + w_sb;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : axi_burst_addr_gen
// Purpose  : Slave-side AXI burst address generator. Takes one AW/AR command
//            and produces one address per beat under valid/ready, with
//            zero-bubble chaining of back-to-back commands and flagging of
//            illegal commands (which still execute, clamped / as INCR).
// Options  : AXI_BURST_STRB_EN adds o_beat_strb (byte lanes of each beat).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module axi_burst_addr_gen
  import axi_burst_pkg::*;
#(
  parameter int AW  = 12,
  parameter int DW  = 32,
  parameter int IDW = 4
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           i_cmd_valid,
  output logic           o_cmd_ready,
  input  logic [AW-1:0]  i_cmd_addr,
  input  logic [7:0]     i_cmd_len,
  input  logic [2:0]     i_cmd_size,
  input  logic [1:0]     i_cmd_burst,
  input  logic [IDW-1:0] i_cmd_id,
  output logic           o_cmd_err,
  output logic           o_beat_valid,
  input  logic           i_beat_ready,
  output logic [AW-1:0]  o_beat_addr,
  output logic [IDW-1:0] o_beat_id,
  output logic [7:0]     o_beat_idx,
  output logic           o_beat_last
`ifdef AXI_BURST_STRB_EN
  ,output logic [DW/8-1:0] o_beat_strb
`endif
);

  localparam int         NB         = DW / 8;
  localparam logic [2:0] MAX_SIZE_L = 3'($clog2(NB));

  state_e         state_q, state_d;
  logic           valid_q, valid_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [7:0]     idx_q, idx_d;
  logic           last_q, last_d;
  logic           err_q, err_d;
  logic [7:0]     len_q, len_d;
  logic [2:0]     size_q, size_d;
  logic [1:0]     burst_q, burst_d;
  logic [AW-1:0]  wrap_lo_q, wrap_lo_d;
  logic [AW-1:0]  wrap_mask_q, wrap_mask_d;

  logic           w_accept;
  logic           w_fire;
  logic           w_oversize;
  logic [2:0]     w_size_cl;
  logic [AW-1:0]  w_cmd_sb;
  logic [AW-1:0]  w_span;
  logic [AW-1:0]  w_mask;
  logic [AW-1:0]  w_wrap_lo;
  logic           w_wrap_ok;
  logic           w_bad_burst;
  logic [1:0]     w_eff_burst;
  logic           w_illegal;
  logic [AW-1:0]  w_next_addr;

`ifdef AXI_BURST_STRB_EN
  logic [NB-1:0]  strb_q, strb_d;

  // Lanes from the beat's byte offset up to the end of its size-aligned container.
  function automatic logic [NB-1:0] lane_strb(input logic [AW-1:0] addr,
                                              input logic [2:0]    size);
    int unsigned off, lo, sb;
    lane_strb = '0;
    sb  = size_bytes(size);
    off = 32'(addr) % 32'(NB);
    lo  = off - (off % sb);
    for (int unsigned i = 0; i < 32'(NB); i++) begin
      lane_strb[i] = (i >= off) && (i < lo + sb);
    end
  endfunction
`endif

  // Handshakes: ready in IDLE, or while the final beat is being consumed.
  assign w_fire      = valid_q & i_beat_ready;
  assign o_cmd_ready = (state_q == IDLE) | (w_fire & last_q);
  assign w_accept    = i_cmd_valid & o_cmd_ready;

  // Command legality and wrap geometry, evaluated on the incoming command.
  assign w_oversize  = (i_cmd_size > MAX_SIZE_L);
  assign w_size_cl   = w_oversize ? MAX_SIZE_L : i_cmd_size;
  assign w_cmd_sb    = AW'(size_bytes(w_size_cl));
  assign w_span      = AW'(({24'd0, i_cmd_len} + 32'd1) << w_size_cl);
  assign w_mask      = w_span - AW'(1);
  assign w_wrap_lo   = i_cmd_addr & ~w_mask;
  assign w_wrap_ok   = wrap_legal(i_cmd_len) && ((i_cmd_addr & (w_cmd_sb - AW'(1))) == '0);
  assign w_bad_burst = (i_cmd_burst == BURST_RSVD) ||
                       ((i_cmd_burst == BURST_WRAP) && !w_wrap_ok);
  assign w_eff_burst = w_bad_burst ? BURST_INCR : i_cmd_burst;
  assign w_illegal   = w_bad_burst | w_oversize;

  axi_beat_step #(
    .AW (AW)
  ) u_step (
    .addr_i      (addr_q),
    .size_i      (size_q),
    .burst_i     (burst_q),
    .wrap_lo_i   (wrap_lo_q),
    .wrap_mask_i (wrap_mask_q),
    .next_addr_o (w_next_addr)
  );

  // Next-state: load on accept, step on a non-final beat, idle after the last.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    addr_d      = addr_q;
    id_d        = id_q;
    idx_d       = idx_q;
    last_d      = last_q;
    err_d       = 1'b0;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    wrap_lo_d   = wrap_lo_q;
    wrap_mask_d = wrap_mask_q;
`ifdef AXI_BURST_STRB_EN
    strb_d      = strb_q;
`endif
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          state_d = BURST;
        end
      end
      BURST: begin
        if (w_fire && last_q && !w_accept) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (w_accept) begin
      valid_d     = 1'b1;
      addr_d      = i_cmd_addr;
      id_d        = i_cmd_id;
      idx_d       = 8'd0;
      last_d      = (i_cmd_len == 8'd0);
      err_d       = w_illegal;
      len_d       = i_cmd_len;
      size_d      = w_size_cl;
      burst_d     = w_eff_burst;
      wrap_lo_d   = w_wrap_lo;
      wrap_mask_d = w_mask;
`ifdef AXI_BURST_STRB_EN
      strb_d      = lane_strb(i_cmd_addr, w_size_cl);
`endif
    end else if (w_fire && !last_q) begin
      addr_d      = w_next_addr;
      idx_d       = idx_q + 8'd1;
      last_d      = ((idx_q + 8'd1) == len_q);
`ifdef AXI_BURST_STRB_EN
      strb_d      = lane_strb(w_next_addr, size_q);
`endif
    end
  end

  // State and beat registers; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      addr_q      <= '0;
      id_q        <= '0;
      idx_q       <= 8'd0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      len_q       <= 8'd0;
      size_q      <= 3'd0;
      burst_q     <= BURST_FIXED;
      wrap_lo_q   <= '0;
      wrap_mask_q <= '0;
`ifdef AXI_BURST_STRB_EN
      strb_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      id_q        <= id_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      err_q       <= err_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      wrap_lo_q   <= wrap_lo_d;
      wrap_mask_q <= wrap_mask_d;
`ifdef AXI_BURST_STRB_EN
      strb_q      <= strb_d;
`endif
    end
  end

  assign o_beat_valid = valid_q;
  assign o_beat_addr  = addr_q;
  assign o_beat_id    = id_q;
  assign o_beat_idx   = idx_q;
  assign o_beat_last  = last_q;
  assign o_cmd_err    = err_q;
`ifdef AXI_BURST_STRB_EN
  assign o_beat_strb  = strb_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_addr_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_axi_burst_addr_gen
// Purpose  : Self-checking bench for axi_burst_addr_gen (AW=12, DW=32, IDW=4).
//            Expected beats come from closed-form burst arithmetic.
// Options  : AXI_BURST_STRB_EN also checks o_beat_strb.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_axi_burst_addr_gen;

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  id;
  } cmd_t;

  logic        clk;
  logic        rstn;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [11:0] i_cmd_addr;
  logic [7:0]  i_cmd_len;
  logic [2:0]  i_cmd_size;
  logic [1:0]  i_cmd_burst;
  logic [3:0]  i_cmd_id;
  logic        o_cmd_err;
  logic        o_beat_valid;
  logic        i_beat_ready;
  logic [11:0] o_beat_addr;
  logic [3:0]  o_beat_id;
  logic [7:0]  o_beat_idx;
  logic        o_beat_last;
`ifdef AXI_BURST_STRB_EN
  logic [3:0]  o_beat_strb;
`endif

  int   n_cmp = 0;
  int   n_err = 0;
  cmd_t seq_q[$];

  axi_burst_addr_gen #(
    .AW  (12),
    .DW  (32),
    .IDW (4)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_cmd_valid  (i_cmd_valid),
    .o_cmd_ready  (o_cmd_ready),
    .i_cmd_addr   (i_cmd_addr),
    .i_cmd_len    (i_cmd_len),
    .i_cmd_size   (i_cmd_size),
    .i_cmd_burst  (i_cmd_burst),
    .i_cmd_id     (i_cmd_id),
    .o_cmd_err    (o_cmd_err),
    .o_beat_valid (o_beat_valid),
    .i_beat_ready (i_beat_ready),
    .o_beat_addr  (o_beat_addr),
    .o_beat_id    (o_beat_id),
    .o_beat_idx   (o_beat_idx),
    .o_beat_last  (o_beat_last)
`ifdef AXI_BURST_STRB_EN
    ,.o_beat_strb (o_beat_strb)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (AXI burst rules, DW=32) ----------------
  function automatic int eff_size(input cmd_t c);
    return (c.size > 3'd2) ? 2 : int'(c.size);
  endfunction

  function automatic bit wrap_ok(input cmd_t c);
    int sb = 1 << eff_size(c);
    return (c.len == 1 || c.len == 3 || c.len == 7 || c.len == 15) &&
           ((int'(c.addr) % sb) == 0);
  endfunction

  function automatic bit exp_err(input cmd_t c);
    return (c.burst == 2'b11) || (c.size > 3'd2) || (c.burst == 2'b10 && !wrap_ok(c));
  endfunction

  function automatic int eff_burst(input cmd_t c);
    if (c.burst == 2'b11 || (c.burst == 2'b10 && !wrap_ok(c))) return 1;
    return int'(c.burst);
  endfunction

  function automatic logic [11:0] exp_addr(input cmd_t c, input int k);
    int a    = int'(c.addr);
    int sb   = 1 << eff_size(c);
    int span = (int'(c.len) + 1) * sb;
    case (eff_burst(c))
      0:       return c.addr;
      2:       return 12'((a - a % span) + ((a % span + k * sb) % span));
      default: return (k == 0) ? c.addr : 12'(((a - a % sb) + k * sb) % 4096);
    endcase
  endfunction

  function automatic logic [3:0] exp_strb(input cmd_t c, input int k);
    int off = int'(exp_addr(c, k)) % 4;
    int sb  = 1 << eff_size(c);
    int lo  = off - off % sb;
    logic [3:0] s = 4'b0000;
    for (int i = 0; i < 4; i++) s[i] = (i >= off) && (i < lo + sb);
    return s;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_cmd(input cmd_t c);
    i_cmd_valid = 1'b1;
    i_cmd_addr  = c.addr;
    i_cmd_len   = c.len;
    i_cmd_size  = c.size;
    i_cmd_burst = c.burst;
    i_cmd_id    = c.id;
  endtask

  // Runs every command in seq_q, offering each next command during the
  // current burst's final beat. mode: 0 ready high, 1 ready 1010..., 2 random.
  task automatic run_seq(input int mode);
    cmd_t cur;
    int   k = 0, cyc = 0, since = 0;
    bit   rdy, offer;
    cur = seq_q.pop_front();
    drive_cmd(cur);
    #1;
    chk("idle_cmd_ready", 32'(o_cmd_ready), 32'd1);
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
    while (1) begin
      if (cyc > 4000) begin
        chk("burst_timeout", 32'(cyc), 32'd0);
        break;
      end
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      i_beat_ready = rdy;
      offer = (k == int'(cur.len)) && (seq_q.size() > 0);
      if (offer) drive_cmd(seq_q[0]);
      else       i_cmd_valid = 1'b0;
      #1;
      chk("beat_valid", 32'(o_beat_valid), 32'd1);
      chk("beat_addr",  32'(o_beat_addr),  32'(exp_addr(cur, k)));
      chk("beat_idx",   32'(o_beat_idx),   32'(k));
      chk("beat_last",  32'(o_beat_last),  32'(k == int'(cur.len)));
      chk("beat_id",    32'(o_beat_id),    32'(cur.id));
      chk("cmd_err",    32'(o_cmd_err),    32'((since == 0) ? exp_err(cur) : 1'b0));
      chk("cmd_ready",  32'(o_cmd_ready),  32'(rdy && (k == int'(cur.len))));
`ifdef AXI_BURST_STRB_EN
      chk("beat_strb",  32'(o_beat_strb),  32'(exp_strb(cur, k)));
`endif
      @(posedge clk); #1;
      cyc++;
      since++;
      if (rdy) begin
        if (k == int'(cur.len)) begin
          if (!offer) break;
          cur   = seq_q.pop_front();
          k     = 0;
          since = 0;
          i_cmd_valid = 1'b0;
        end else begin
          k++;
        end
      end
    end
    i_beat_ready = 1'b0;
    i_cmd_valid  = 1'b0;
    #1;
    chk("end_valid_low", 32'(o_beat_valid), 32'd0);
    chk("end_cmd_ready", 32'(o_cmd_ready),  32'd1);
    @(posedge clk); #1;
  endtask

  function automatic cmd_t mk(input logic [11:0] a, input logic [7:0] l,
                              input logic [2:0] s, input logic [1:0] b, input logic [3:0] id);
    cmd_t c;
    c.addr = a; c.len = l; c.size = s; c.burst = b; c.id = id;
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.burst = 2'($urandom_range(0, 3));
    c.size  = 3'($urandom_range(0, 3));
    c.len   = 8'($urandom_range(0, 9));
    c.addr  = 12'($urandom);
    c.id    = 4'($urandom);
    if (c.burst == 2'b10) begin
      // Keep WRAP within the clamp-free size range; make most of them legal.
      c.size = 3'($urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 3))
          0:       c.len = 8'd1;
          1:       c.len = 8'd3;
          2:       c.len = 8'd7;
          default: c.len = 8'd15;
        endcase
        c.addr = c.addr & ~(12'(1) << c.size) + 12'd0;
        c.addr = 12'((int'(c.addr) >> c.size) << c.size);
      end
    end
    return c;
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    rstn = 1'b0;
    i_cmd_valid = 1'b0; i_cmd_addr = '0; i_cmd_len = '0; i_cmd_size = '0;
    i_cmd_burst = '0; i_cmd_id = '0; i_beat_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(o_beat_valid), 32'd0);
    chk("rst_addr",  32'(o_beat_addr),  32'd0);
    chk("rst_id",    32'(o_beat_id),    32'd0);
    chk("rst_idx",   32'(o_beat_idx),   32'd0);
    chk("rst_last",  32'(o_beat_last),  32'd0);
    chk("rst_err",   32'(o_cmd_err),    32'd0);
    chk("rst_ready", 32'(o_cmd_ready),  32'd1);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;

    // WRAP 0x078 len 3 size 2: 0x078, 0x07C, 0x070, 0x074.
    seq_q.push_back(mk(12'h078, 8'd3, 3'd2, 2'b10, 4'h1));
    run_seq(0);
    // INCR from unaligned 0x0FE, len 7, size 2.
    seq_q.push_back(mk(12'h0FE, 8'd7, 3'd2, 2'b01, 4'h2));
    run_seq(0);
    // FIXED 0x040 with ready toggling.
    seq_q.push_back(mk(12'h040, 8'd3, 3'd2, 2'b00, 4'h3));
    run_seq(1);
    // Two INCR commands chained with no bubble.
    seq_q.push_back(mk(12'h300, 8'd2, 3'd2, 2'b01, 4'h4));
    seq_q.push_back(mk(12'h401, 8'd3, 3'd0, 2'b01, 4'h5));
    run_seq(0);
    // Illegal: WRAP len 2, then oversize, then reserved burst.
    seq_q.push_back(mk(12'h010, 8'd2, 3'd2, 2'b10, 4'h6));
    run_seq(0);
    seq_q.push_back(mk(12'h020, 8'd3, 3'd3, 2'b01, 4'h7));
    run_seq(0);
    seq_q.push_back(mk(12'h033, 8'd2, 3'd1, 2'b11, 4'h8));
    run_seq(1);
    // Address wrap at top of space.
    seq_q.push_back(mk(12'hFFC, 8'd1, 3'd2, 2'b01, 4'h9));
    run_seq(0);
    // Single-beat bursts of every type, chained.
    seq_q.push_back(mk(12'h104, 8'd0, 3'd2, 2'b00, 4'hA));
    seq_q.push_back(mk(12'h105, 8'd0, 3'd0, 2'b01, 4'hB));
    seq_q.push_back(mk(12'h108, 8'd0, 3'd2, 2'b10, 4'hC));
    run_seq(0);

    // Reset asserted mid-burst abandons the burst.
    drive_cmd(mk(12'h200, 8'd7, 3'd2, 2'b01, 4'hD));
    @(posedge clk); #1;
    i_cmd_valid  = 1'b0;
    i_beat_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_addr", 32'(o_beat_addr), 32'h208);
    rstn = 1'b0;
    #2;
    chk("mid_rst_valid", 32'(o_beat_valid), 32'd0);
    chk("mid_rst_addr",  32'(o_beat_addr),  32'd0);
    chk("mid_rst_id",    32'(o_beat_id),    32'd0);
    chk("mid_rst_idx",   32'(o_beat_idx),   32'd0);
    chk("mid_rst_last",  32'(o_beat_last),  32'd0);
    i_beat_ready = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(o_cmd_ready),  32'd1);
    chk("post_rst_valid", 32'(o_beat_valid), 32'd0);

    // Randomized groups under random backpressure.
    for (int g = 0; g < 25; g++) begin
      int n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) seq_q.push_back(rand_cmd());
      run_seq(2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
